// File: rtl/pio_write_arbiter_if.sv
// ============================================================================
// Module   : pio_write_arbiter_if
// Brief    : Requester handshake and PIO write-port bundle for pio_write_arbiter.
//            Optional macro: PIO_ARB_GRANT_CNT_EN (adds grant_cnt).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pio_write_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 64
);
    localparam int c_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         avs_s0_write;
    logic [BUS_WIDTH-1:0]         avs_s0_writedata;
    logic [c_ID_W-1:0]            grant_id;
    logic                         busy;
`ifdef PIO_ARB_GRANT_CNT_EN
    logic [NUM_REQ*16-1:0]        grant_cnt;

    modport master (
        output req_valid, req_data,
        input  req_ready, avs_s0_write, avs_s0_writedata, grant_id, busy, grant_cnt
    );
    modport slave (
        input  req_valid, req_data,
        output req_ready, avs_s0_write, avs_s0_writedata, grant_id, busy, grant_cnt
    );
`else
    modport master (
        output req_valid, req_data,
        input  req_ready, avs_s0_write, avs_s0_writedata, grant_id, busy
    );
    modport slave (
        input  req_valid, req_data,
        output req_ready, avs_s0_write, avs_s0_writedata, grant_id, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/pio_write_arbiter.sv
// ============================================================================
// Module   : pio_write_arbiter
// Brief    : Round-robin arbiter sharing one PIO register write port, with a
//            programmable idle gap. Optional macro: PIO_ARB_GRANT_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pio_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BUS_WIDTH  = 64,
    parameter int GAP_CYCLES = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    pio_write_arbiter_if.slave  bus
);
    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST =
        c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_GAP_W-1:0]   gap_q, gap_d;
    logic [c_ID_W-1:0]    last_q;
    logic [c_ID_W-1:0]    grant_q;
    logic [BUS_WIDTH-1:0] data_q;

    logic                 w_found;
    logic [c_ID_W-1:0]    w_win;
    logic [BUS_WIDTH-1:0] w_sel;
    logic                 w_accept;
    logic [NUM_REQ-1:0]   w_ready;
    int                   w_dist;
    int                   w_best;

    // Winner = valid requester with the smallest rotational distance past last_q.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_best  = NUM_REQ;
        w_dist  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(last_q)) % NUM_REQ;
            if (bus.req_valid[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_win   = c_ID_W'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == c_ID_W'(i)) begin
                w_sel = bus.req_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    assign w_accept = (state_q == S_IDLE) && w_found;
    assign w_ready  = w_accept ? (NUM_REQ'(1) << w_win) : '0;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                gap_d   = '0;
                state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            last_q  <= c_ID_W'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (w_accept) begin
                last_q  <= w_win;
                grant_q <= w_win;
                data_q  <= w_sel;
            end
        end
    end

    assign bus.req_ready        = w_ready;
    assign bus.avs_s0_write     = (state_q == S_WRITE);
    assign bus.avs_s0_writedata = data_q;
    assign bus.grant_id         = grant_q;
    assign bus.busy             = (state_q != S_IDLE);

`ifdef PIO_ARB_GRANT_CNT_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (w_ready[g] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign bus.grant_cnt[g*16 +: 16] = cnt_q;
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_pio_write_arbiter.sv
// ============================================================================
// Module   : tb_pio_write_arbiter
// Brief    : Randomized and directed bench for pio_write_arbiter against an
//            accept-schedule reference model. Optional macro: PIO_ARB_GRANT_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pio_write_arbiter;
    localparam int N   = 4;
    localparam int W   = 64;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pio_write_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W)) bus ();
    pio_write_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W)) bus0 ();

    pio_write_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W), .GAP_CYCLES(GAP)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    pio_write_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W), .GAP_CYCLES(0)) u_dut_gap0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: the arbiter as a schedule of accept slots, not as a state machine.
    int          cyc;
    int          m_last;
    int          m_acc;
    int          m_nf;
    logic [63:0] m_data;
    int          m_grant;
    int          m_cnt [N];

    task automatic model_reset();
        cyc     = 0;
        m_last  = N - 1;
        m_acc   = -100;
        m_nf    = 0;
        m_data  = '0;
        m_grant = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic do_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                            output int acc, output logic wr, output logic [W-1:0] wd);
        logic [N-1:0] er;
        int w;
        @(posedge clk);
        #1;
        bus.req_valid = v;
        bus.req_data  = d;
        #3;
        w = -1;
        if (cyc >= m_nf) begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
            end
        end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        check_eq("req_ready", bus.req_ready, er);
        check_eq("write", bus.avs_s0_write, cyc == m_acc + 1);
        check_eq("writedata", bus.avs_s0_writedata, m_data);
        check_eq("grant_id", bus.grant_id, m_grant);
        check_eq("busy", bus.busy, (cyc > m_acc) && (cyc < m_nf));
        wr = bus.avs_s0_write;
        wd = bus.avs_s0_writedata;
        if (w >= 0) begin
            m_acc   = cyc;
            m_nf    = cyc + 2 + GAP;
            m_last  = w;
            m_data  = d[w*W +: W];
            m_grant = w;
            if (m_cnt[w] < 65535) m_cnt[w]++;
        end
        acc = w;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   pv;
        logic           wr, prev;
        logic [W-1:0]   wd;
        int             acc, k, c0, eid;

        n_checks = 0;
        n_fail   = 0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus0.req_valid = '0;
        bus0.req_data  = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_write", bus.avs_s0_write, 0);
        check_eq("rst_wdata", bus.avs_s0_writedata, 0);
        check_eq("rst_grant", bus.grant_id, 0);
        check_eq("rst_busy", bus.busy, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Single requester 2: strobes at cycles 1, 5, 9.
        d = '0;
        d[2*W +: W] = 64'h0123_4567_89AB_CDEF;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            do_cycle(4'b0100, d, acc, wr, wd);
            if (wr) begin
                check_eq("single_data", wd, 64'h0123_4567_89AB_CDEF);
                check_eq("single_cyc", c, 4 * k + 1);
                k++;
            end
        end
        check_eq("single_count", k, 3);

        // Withdrawal: requester 1 valid only while the arbiter is in its gap.
        d = '0;
        d[0 +: W] = 64'h55;
        d[W +: W] = 64'h77;
        do_cycle(4'b0001, d, acc, wr, wd);
        do_cycle(4'b0000, d, acc, wr, wd);
        k = 0;
        for (int c = 0; c < 5; c++) begin
            do_cycle((c < 2) ? 4'b0010 : 4'b0000, d, acc, wr, wd);
            if (wr) k++;
        end
        check_eq("withdraw_strobes", k, 0);
        check_eq("withdraw_busy", bus.busy, 0);

        // Asynchronous reset during the write strobe.
        for (int i = 0; i < N; i++) d[i*W +: W] = 64'hA0 + 64'(i);
        acc = -1;
        for (int c = 0; c < 8 && acc < 0; c++) do_cycle(4'b1111, d, acc, wr, wd);
        check_eq("arst_accept_seen", acc >= 0, 1);
        @(posedge clk);
        #1;
        check_eq("arst_write_before", bus.avs_s0_write, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("arst_write_drop", bus.avs_s0_write, 0);
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_wdata", bus.avs_s0_writedata, 0);
        check_eq("arst_grant", bus.grant_id, 0);
        bus.req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // All four continuously valid: A0, A1, A2, A3, A0 spaced 4 cycles.
        k = 0;
        for (int c = 0; c < 18; c++) begin
            do_cycle(4'b1111, d, acc, wr, wd);
            if (wr) begin
                check_eq("rr_data", wd, 64'hA0 + 64'(k % 4));
                check_eq("rr_cyc", c, 4 * k + 1);
                k++;
            end
        end
        check_eq("rr_count", k, 5);

        // Randomized requesters holding valid/data until accepted, with withdrawals.
        pv  = '0;
        acc = -1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pv[i] && acc == i) begin
                    pv[i] = 1'($urandom % 2);
                    d[i*W +: W] = {$urandom, $urandom};
                end else if (pv[i] && ($urandom % 16 == 0)) begin
                    pv[i] = 1'b0;
                end else if (!pv[i] && ($urandom % 3 == 0)) begin
                    pv[i] = 1'b1;
                    d[i*W +: W] = {$urandom, $urandom};
                end
            end
            do_cycle(pv, d, acc, wr, wd);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;

        // Zero-gap instance: requesters 1 and 3 alternate every 2 cycles.
        for (int i = 0; i < N; i++) bus0.req_data[i*W +: W] = 64'hB0 + 64'(i);
        bus0.req_valid = 4'b1010;
        prev = 1'b0;
        eid  = 1;
        c0   = 0;
        for (int c = 0; c < 14; c++) begin
            #3;
            wr = bus0.avs_s0_write;
            if (wr) begin
                check_eq("g0_back_to_back", prev, 0);
                check_eq("g0_grant", bus0.grant_id, eid);
                check_eq("g0_data", bus0.avs_s0_writedata, 64'hB0 + 64'(eid));
                check_eq("g0_cyc", c, 2 * c0 + 1);
                eid = (eid == 1) ? 3 : 1;
                c0++;
            end
            prev = wr;
            @(posedge clk);
            #1;
        end
        check_eq("g0_count", c0, 7);
        bus0.req_valid = '0;

`ifdef PIO_ARB_GRANT_CNT_EN
        for (int i = 0; i < N; i++) begin
            check_eq("grant_cnt", bus.grant_cnt[i*16 +: 16], 64'(m_cnt[i]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
